// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit saturating counters behind one access port,
// arbitrating fetch lookups against buffered commit updates with bounded update starvation.
module bht_ctrl #(
  parameter int IDX_W        = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lk_valid,
  input  logic [63:0]                   lk_pc,
  output logic                          lk_ready,
  output logic                          rsp_valid,
  output logic                          rsp_taken,
  output logic [1:0]                    rsp_ctr,
  input  logic                          up_valid,
  input  logic [63:0]                   up_pc,
  input  logic                          up_taken,
  output logic                          up_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int SC_W    = $clog2(STARVE_LIMIT + 1);

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

  logic [1:0]       tbl [ENTRIES];
  logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
  logic             q_tkn [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic [SC_W-1:0]  starve;
  logic             vld_p1;
  logic [1:0]       ctr_p1;

  logic             empty, full, enq, up_grant, lk_grant;
  logic [IDX_W-1:0] lk_idx, up_idx, hd_idx;
  logic             hd_tkn;
  logic             unused_pc_bits;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lk_pc[63:IDX_W+2], lk_pc[1:0], up_pc[63:IDX_W+2], up_pc[1:0]};

  // Arbitration works from registered occupancy, so a same-cycle enqueue can never be drained.
  always_comb begin
    empty    = (count == '0);
    full     = (count == LVL_W'(FIFO_DEPTH));
    enq      = up_valid && !full;
    hd_idx   = q_idx[rd_ptr];
    hd_tkn   = q_tkn[rd_ptr];
    up_grant = !empty && (full || !lk_valid || (starve == SC_W'(STARVE_LIMIT)));
    lk_grant = lk_valid && !up_grant;
  end

  assign lk_ready   = lk_grant;
  assign up_ready   = !full;
  assign fifo_level = count;
  assign rsp_valid  = vld_p1;
  assign rsp_ctr    = ctr_p1;
  assign rsp_taken  = ctr_p1[1];

  // Stage p0 -> p1: FIFO control, starvation tracking and lookup response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
      vld_p1 <= 1'b0;
      ctr_p1 <= 2'b00;
    end else begin
      if (enq)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (up_grant) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, up_grant})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      if (empty || up_grant)
        starve <= '0;
      else if (lk_grant && (starve != SC_W'(STARVE_LIMIT)))
        starve <= starve + SC_W'(1);
      vld_p1 <= lk_grant;
      if (lk_grant) ctr_p1 <= tbl[lk_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx[wr_ptr] <= up_idx;
      q_tkn[wr_ptr] <= up_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
    end else if (up_grant) begin
      tbl[hd_idx] <= sat_update(tbl[hd_idx], hd_tkn);
    end
  end

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl: lookup latency, saturation, starvation, FIFO full, stale reads, reset.
module tb_bht_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lk_valid = 1'b0;
  logic [63:0] lk_pc = '0;
  logic        lk_ready;
  logic        rsp_valid, rsp_taken;
  logic [1:0]  rsp_ctr;
  logic        up_valid = 1'b0;
  logic [63:0] up_pc = '0;
  logic        up_taken = 1'b0;
  logic        up_ready;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  bht_ctrl dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_taken(rsp_taken), .rsp_ctr(rsp_ctr),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [63:0] pc, input logic [1:0] exp, input string nm);
    lk_valid = 1'b1;
    lk_pc    = pc;
    #1;
    checks++;
    if (lk_ready !== 1'b1) begin
      errors++; $display("FAIL %s lk_ready got %b want 1", nm, lk_ready);
    end
    step();
    lk_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_ctr !== exp || rsp_taken !== exp[1]) begin
      errors++;
      $display("FAIL %s rsp got vld=%b ctr=%b tkn=%b want vld=1 ctr=%b tkn=%b",
               nm, rsp_valid, rsp_ctr, rsp_taken, exp, exp[1]);
    end
  endtask

  task automatic do_update(input logic [63:0] pc, input logic tkn, input string nm);
    up_valid = 1'b1;
    up_pc    = pc;
    up_taken = tkn;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin
      errors++; $display("FAIL %s up_ready got %b want 1", nm, up_ready);
    end
    step();
    up_valid = 1'b0;
    step();
    step();
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL %s drain level got %0d want 0", nm, fifo_level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_ctr !== 2'b00 || rsp_taken !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got vld=%b ctr=%b tkn=%b want 0 00 0", rsp_valid, rsp_ctr, rsp_taken);
    end
    checks++;
    if (fifo_level !== 3'd0 || up_ready !== 1'b1 || lk_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got lvl=%0d up_rdy=%b lk_rdy=%b want 0 1 0", fifo_level, up_ready, lk_ready);
    end
  endtask

  task automatic test_lookup_basic();
    do_lookup(64'h8000_0010, 2'b01, "lookup_basic");
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_ctr !== 2'b01) begin
      errors++; $display("FAIL rsp_hold got vld=%b ctr=%b want 0 01", rsp_valid, rsp_ctr);
    end
  endtask

  task automatic test_update_sat();
    do_update(64'h8000_0010, 1'b1, "upd_t1");
    do_lookup(64'h8000_0010, 2'b10, "sat_step1");
    do_update(64'h8000_0010, 1'b1, "upd_t2");
    do_lookup(64'h8000_0010, 2'b11, "sat_step2");
    do_update(64'h8000_0010, 1'b1, "upd_t3");
    do_lookup(64'h8000_0010, 2'b11, "sat_step3");
    do_lookup(64'h0000_1010, 2'b11, "alias");
  endtask

  task automatic test_starve();
    lk_valid = 1'b1; lk_pc = 64'h0;
    up_valid = 1'b1; up_pc = 64'h20; up_taken = 1'b1;
    #1;
    checks++;
    if (lk_ready !== 1'b1) begin
      errors++; $display("FAIL starve_c0 lk_ready got %b want 1", lk_ready);
    end
    step();
    up_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lk_ready !== 1'b1 || fifo_level !== 3'd1) begin
        errors++; $display("FAIL starve_grant%0d got lk_rdy=%b lvl=%0d want 1 1", i, lk_ready, fifo_level);
      end
      step();
    end
    checks++;
    if (lk_ready !== 1'b0 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL starve_upd got lk_rdy=%b lvl=%0d want 0 1", lk_ready, fifo_level);
    end
    step();
    checks++;
    if (lk_ready !== 1'b1 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL starve_resume got lk_rdy=%b lvl=%0d want 1 0", lk_ready, fifo_level);
    end
    lk_valid = 1'b0;
    step();
    do_lookup(64'h20, 2'b10, "starve_result");
  endtask

  task automatic test_full();
    lk_valid = 1'b1; lk_pc = 64'h0;
    up_valid = 1'b1; up_pc = 64'h40; up_taken = 1'b0;
    #1;
    checks++;
    if (up_ready !== 1'b1 || lk_ready !== 1'b1) begin
      errors++; $display("FAIL full_e0 got up_rdy=%b lk_rdy=%b want 1 1", up_ready, lk_ready);
    end
    repeat (4) step();
    up_valid = 1'b0;
    #1;
    checks++;
    if (fifo_level !== 3'd4 || up_ready !== 1'b0 || lk_ready !== 1'b0) begin
      errors++; $display("FAIL full_at4 got lvl=%0d up_rdy=%b lk_rdy=%b want 4 0 0", fifo_level, up_ready, lk_ready);
    end
    step();
    checks++;
    if (fifo_level !== 3'd3 || up_ready !== 1'b1 || lk_ready !== 1'b1) begin
      errors++; $display("FAIL full_after got lvl=%0d up_rdy=%b lk_rdy=%b want 3 1 1", fifo_level, up_ready, lk_ready);
    end
    lk_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL full_drain got lvl=%0d want 0", fifo_level);
    end
    do_lookup(64'h40, 2'b00, "full_result");
  endtask

  task automatic test_stale();
    lk_valid = 1'b1; lk_pc = 64'h30;
    up_valid = 1'b1; up_pc = 64'h30; up_taken = 1'b0;
    #1;
    checks++;
    if (lk_ready !== 1'b1) begin
      errors++; $display("FAIL stale_s0 lk_ready got %b want 1", lk_ready);
    end
    step();
    up_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_ctr !== 2'b01 || lk_ready !== 1'b1) begin
      errors++; $display("FAIL stale_s1 got vld=%b ctr=%b lk_rdy=%b want 1 01 1", rsp_valid, rsp_ctr, lk_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_ctr !== 2'b01 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL stale_pending got vld=%b ctr=%b lvl=%0d want 1 01 1", rsp_valid, rsp_ctr, fifo_level);
    end
    lk_valid = 1'b0;
    step();
    do_lookup(64'h30, 2'b00, "stale_drained");
    do_update(64'h30, 1'b0, "upd_nt_floor");
    do_lookup(64'h30, 2'b00, "floor_sat");
  endtask

  task automatic test_reset_mid();
    lk_valid = 1'b1; lk_pc = 64'h10;
    up_valid = 1'b1; up_pc = 64'h50; up_taken = 1'b1;
    repeat (3) step();
    up_valid = 1'b0;
    #1;
    checks++;
    if (fifo_level !== 3'd3 || lk_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got lvl=%0d lk_rdy=%b want 3 1", fifo_level, lk_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    lk_valid = 1'b0;
    #1;
    checks++;
    if (fifo_level !== 3'd0 || rsp_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_post got lvl=%0d vld=%b up_rdy=%b want 0 0 1", fifo_level, rsp_valid, up_ready);
    end
    do_lookup(64'h10, 2'b01, "rstmid_idx4");
    do_lookup(64'h20, 2'b01, "rstmid_idx8");
    do_lookup(64'h30, 2'b01, "rstmid_idx12");
    do_lookup(64'h40, 2'b01, "rstmid_idx16");
    do_lookup(64'h50, 2'b01, "rstmid_idx20");
  endtask

  initial begin
    test_reset();
    test_lookup_basic();
    test_update_sat();
    test_starve();
    test_full();
    test_stale();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
